// File: rtl/disp_arb_pkg.sv
// disp_arb_pkg: shared states, channel indices and default blank word for disp_arbiter
package disp_arb_pkg;
    typedef enum logic [1:0] {
        S_LIVE  = 2'd0,
        S_MSG   = 2'd1,
        S_ALERT = 2'd2
    } state_t;
    localparam int CH_LIVE = 0;
    localparam int CH_MSG = 1;
    localparam int CH_ALERT = 2;
    localparam logic [31:0] DEFAULT_BLANK_WORD = 32'hFFFF_FFFF;
    function automatic logic [2:0] grant_of(input state_t s);
        return s == S_ALERT ? 3'b001 << CH_ALERT : s == S_MSG ? 3'b001 << CH_MSG : 3'b001 << CH_LIVE;
    endfunction
endpackage

// File: rtl/hold_timer.sv
// hold_timer: loadable down-counter that stops at zero; expired is high while the count is zero
module hold_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] value,
    output logic         expired
);
    logic [W-1:0] count;
    always_ff @(posedge clk) begin
        if (rst || clear) count <= '0;
        else if (load) count <= value;
        else if (count != '0) count <= count - 1'b1;
    end
    assign expired = count == '0;
endmodule

// File: rtl/disp_arbiter.sv
// disp_arbiter: shares the HEX8 word between live status, held info messages and held alerts.
// Define DISP_ARB_BLINK_EN to blink the alert between its snapshot and BLANK_WORD.
import disp_arb_pkg::*;
module disp_arbiter #(
    parameter int          HOLD_CYCLES = 200_000_000,
    parameter logic [31:0] BLANK_WORD  = DEFAULT_BLANK_WORD,
    parameter int          BLINK_HALF  = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] live_data,
    input  logic        msg_req,
    input  logic [31:0] msg_data,
    input  logic        alert_req,
    input  logic [31:0] alert_data,
    input  logic        dismiss,
    output logic [31:0] disp_data,
    output logic [2:0]  grant,
    output logic        busy
);
    localparam int HW = $clog2(HOLD_CYCLES);
    if (HOLD_CYCLES < 2 || BLINK_HALF < 1) begin : g_bad_params
        $error("disp_arbiter: HOLD_CYCLES must be >= 2 and BLINK_HALF >= 1");
    end
    state_t state, state_n, base;
    logic pm, pa, pm_n, pa_n, fin, load, hold_exp;
    logic [31:0] msg_snap, alert_snap, alert_word;
    // Expiry/dismiss is resolved first into base; any request this cycle then acts on top of it.
    always_comb begin
        fin = state != S_LIVE && (hold_exp || dismiss);
        base = fin ? (pa ? S_ALERT : pm ? S_MSG : S_LIVE) : state;
        pa_n = fin ? 1'b0 : pa;
        pm_n = (fin && !pa) ? 1'b0 : pm;
        load = fin && base != S_LIVE;
        state_n = base;
        if (alert_req) begin
            state_n = S_ALERT;
            load = 1'b1;
            pa_n = 1'b0;
            pm_n = pm_n | (base == S_MSG) | msg_req;
        end else if (msg_req) begin
            state_n = base == S_ALERT ? S_ALERT : S_MSG;
            load = base != S_ALERT;
            pm_n = base == S_ALERT;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_LIVE;
            pm <= 1'b0;
            pa <= 1'b0;
            msg_snap <= '0;
            alert_snap <= '0;
        end else begin
            state <= state_n;
            pm <= pm_n;
            pa <= pa_n;
            if (msg_req) msg_snap <= msg_data;
            if (alert_req) alert_snap <= alert_data;
        end
    end
    hold_timer #(.W(HW)) u_hold (
        .clk(clk),
        .rst(rst),
        .load(load),
        .clear(state_n == S_LIVE),
        .value(HW'(HOLD_CYCLES - 1)),
        .expired(hold_exp)
    );
`ifdef DISP_ARB_BLINK_EN
    localparam int BW = $clog2(BLINK_HALF + 1);
    logic alert_load, blink_exp, phase;
    assign alert_load = load && state_n == S_ALERT;
    hold_timer #(.W(BW)) u_blink (
        .clk(clk),
        .rst(rst),
        .load(alert_load || (state == S_ALERT && blink_exp)),
        .clear(state_n != S_ALERT),
        .value(BW'(BLINK_HALF - 1)),
        .expired(blink_exp)
    );
    always_ff @(posedge clk) begin
        if (rst || alert_load) phase <= 1'b0;
        else if (state == S_ALERT && blink_exp) phase <= ~phase;
    end
    assign alert_word = phase ? BLANK_WORD : alert_snap;
`else
    assign alert_word = alert_snap;
`endif
    assign disp_data = state == S_ALERT ? alert_word : state == S_MSG ? msg_snap : live_data;
    assign grant = grant_of(state);
    assign busy = state != S_LIVE;
endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: directed and random checks of disp_arbiter against an owner/remaining-time model
module tb_disp_arbiter;
    localparam int HOLD = 10;
    localparam int BLINK = 3;
    logic clk = 1'b0, rst = 1'b0, msg_req = 1'b0, alert_req = 1'b0, dismiss = 1'b0;
    logic [31:0] live_data = '0, msg_data = '0, alert_data = '0, disp_data;
    logic [2:0] grant;
    logic busy;
    int compared = 0, mismatched = 0;
    int owner = 0, rem = 0, age = 0;
    bit pend = 0;
    logic [31:0] ms = '0, as = '0;

    disp_arbiter #(.HOLD_CYCLES(HOLD), .BLANK_WORD(32'hFFFF_FFFF), .BLINK_HALF(BLINK)) dut (
        .clk(clk), .rst(rst), .live_data(live_data), .msg_req(msg_req), .msg_data(msg_data),
        .alert_req(alert_req), .alert_data(alert_data), .dismiss(dismiss),
        .disp_data(disp_data), .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    // owner: 0 live, 1 message, 2 alert; rem counts display cycles left including the current one
    task automatic model_step(input logic a, m, d, r, input logic [31:0] ad, md);
        if (r) begin
            owner = 0; rem = 0; pend = 0; ms = '0; as = '0; age = 0;
        end else begin
            if (owner != 0 && (rem == 1 || d)) begin
                owner = pend ? 1 : 0;
                rem = HOLD;
                pend = 0;
            end else if (owner != 0) rem--;
            if (a) begin
                if (owner == 1 || m) pend = 1;
                owner = 2;
                rem = HOLD;
            end else if (m) begin
                if (owner == 2) pend = 1;
                else begin owner = 1; rem = HOLD; end
            end
            age = a ? 0 : age + 1;
            if (m) ms = md;
            if (a) as = ad;
        end
    endtask

    function automatic logic [31:0] exp_disp();
`ifdef DISP_ARB_BLINK_EN
        logic [31:0] aw = ((age / BLINK) % 2) ? 32'hFFFF_FFFF : as;
`else
        logic [31:0] aw = as;
`endif
        return owner == 0 ? live_data : owner == 1 ? ms : aw;
    endfunction

    function automatic logic [2:0] exp_grant();
        return owner == 0 ? 3'b001 : owner == 1 ? 3'b010 : 3'b100;
    endfunction

    task automatic tick(input logic a, m, d, r, input logic [31:0] ad, md, ld);
        alert_req = a; msg_req = m; dismiss = d; rst = r;
        alert_data = ad; msg_data = md; live_data = ld;
        @(posedge clk);
        model_step(a, m, d, r, ad, md);
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(0, 0, 0, 1, 32'h0, 32'h0, $urandom);
        tick(0, 0, 0, 1, 32'h0, 32'h0, $urandom);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, $urandom, $urandom, 32'h1234_5678);
            if (disp_data !== 32'h1234_5678 || grant !== 3'b001 || busy !== 1'b0) begin
                mismatched++;
                $display("FAIL reset i=%0d disp=%h grant=%b busy=%b want 12345678/001/0", i, disp_data, grant, busy);
            end
            compared++;
        end
    endtask

    task automatic test_msg();
        int shown = 0;
        tick(0, 0, 0, 1, 0, 0, $urandom);
        for (int i = 0; i < 13; i++) begin
            tick(0, i == 0, 0, 0, $urandom, 32'h0000_0042, $urandom);
            if (grant === 3'b010 && disp_data === 32'h0000_0042) shown++;
            if (disp_data !== exp_disp() || grant !== exp_grant() || busy !== (owner != 0)) begin
                mismatched++;
                $display("FAIL msg i=%0d disp=%h exp=%h grant=%b exp=%b busy=%b", i, disp_data, exp_disp(), grant, exp_grant(), busy);
            end
            compared++;
        end
        if (shown != HOLD || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL msg_hold shown=%0d busy=%b want %0d/0", shown, busy, HOLD);
        end
        compared++;
    endtask

    task automatic test_preempt();
        int nmsg = 0, nalert = 0;
        tick(0, 0, 0, 1, 0, 0, $urandom);
        for (int i = 0; i < 30; i++) begin
            tick(i == 4, i == 0, 0, 0, 32'hE000_0001, 32'h0000_0042, $urandom);
            if (grant === 3'b010) nmsg++;
            if (grant === 3'b100) nalert++;
            if (disp_data !== exp_disp() || grant !== exp_grant() || busy !== (owner != 0)) begin
                mismatched++;
                $display("FAIL preempt i=%0d disp=%h exp=%h grant=%b exp=%b busy=%b", i, disp_data, exp_disp(), grant, exp_grant(), busy);
            end
            compared++;
        end
        if (nmsg != 4 + HOLD || nalert != HOLD) begin
            mismatched++;
            $display("FAIL preempt_counts msg=%0d alert=%0d want %0d/%0d", nmsg, nalert, 4 + HOLD, HOLD);
        end
        compared++;
    endtask

    task automatic test_same_cycle();
        int nbusy = 0;
        logic [2:0] first = '0;
        tick(0, 0, 0, 1, 0, 0, $urandom);
        for (int i = 0; i < 25; i++) begin
            tick(i == 0, i == 0, 0, 0, 32'hE000_0002, 32'h0000_0077, $urandom);
            if (i == 0) first = grant;
            if (busy === 1'b1) nbusy++;
            if (disp_data !== exp_disp() || grant !== exp_grant() || busy !== (owner != 0)) begin
                mismatched++;
                $display("FAIL same_cycle i=%0d disp=%h exp=%h grant=%b exp=%b busy=%b", i, disp_data, exp_disp(), grant, exp_grant(), busy);
            end
            compared++;
        end
        if (nbusy != 2 * HOLD || first !== 3'b100) begin
            mismatched++;
            $display("FAIL same_cycle_busy busy_cycles=%0d first_grant=%b want %0d/100", nbusy, first, 2 * HOLD);
        end
        compared++;
    endtask

    task automatic test_rerequest();
        int nmsg = 0;
        tick(0, 0, 0, 1, 0, 0, $urandom);
        for (int i = 0; i < 20; i++) begin
            tick(0, i == 0 || i == 5, 0, 0, $urandom, i == 0 ? 32'h11 : 32'h22, $urandom);
            if (grant === 3'b010) nmsg++;
            if (disp_data !== exp_disp() || grant !== exp_grant() || busy !== (owner != 0)) begin
                mismatched++;
                $display("FAIL rerequest i=%0d disp=%h exp=%h grant=%b exp=%b busy=%b", i, disp_data, exp_disp(), grant, exp_grant(), busy);
            end
            compared++;
        end
        if (nmsg != 5 + HOLD) begin
            mismatched++;
            $display("FAIL rerequest_hold msg_cycles=%0d want %0d", nmsg, 5 + HOLD);
        end
        compared++;
    endtask

    task automatic test_dismiss();
        for (int p = 0; p < 2; p++) begin
            tick(0, 0, 0, 1, 0, 0, $urandom);
            for (int i = 0; i < 16; i++) begin
                tick(i == 0, p == 1 && i == 1, i == 3, 0, 32'hE000_0003, 32'h0000_0055, $urandom);
                if (i == 3 && grant !== (p == 1 ? 3'b010 : 3'b001)) begin
                    mismatched++;
                    $display("FAIL dismiss_grant pend=%0d grant=%b want %b", p, grant, p == 1 ? 3'b010 : 3'b001);
                end
                if (i == 3) compared++;
                if (disp_data !== exp_disp() || grant !== exp_grant() || busy !== (owner != 0)) begin
                    mismatched++;
                    $display("FAIL dismiss p=%0d i=%0d disp=%h exp=%h grant=%b exp=%b busy=%b", p, i, disp_data, exp_disp(), grant, exp_grant(), busy);
                end
                compared++;
            end
        end
    endtask

    task automatic test_rst_mid();
        int nmsg = 0;
        tick(0, 0, 0, 1, 0, 0, $urandom);
        for (int i = 0; i < 20; i++) begin
            tick(i == 0, i == 1, 0, i == 5, 32'hE000_0004, 32'h0000_0066, $urandom);
            if (i > 5 && grant === 3'b010) nmsg++;
            if (disp_data !== exp_disp() || grant !== exp_grant() || busy !== (owner != 0)) begin
                mismatched++;
                $display("FAIL rst_mid i=%0d disp=%h exp=%h grant=%b exp=%b busy=%b", i, disp_data, exp_disp(), grant, exp_grant(), busy);
            end
            compared++;
        end
        if (nmsg != 0 || grant !== 3'b001) begin
            mismatched++;
            $display("FAIL rst_mid_pending msg_cycles=%0d grant=%b want 0/001", nmsg, grant);
        end
        compared++;
    endtask

    task automatic test_random();
        tick(0, 0, 0, 1, 0, 0, $urandom);
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 149) == 0, $urandom, $urandom, $urandom);
            if (disp_data !== exp_disp() || grant !== exp_grant() || busy !== (owner != 0)) begin
                mismatched++;
                $display("FAIL random i=%0d disp=%h exp=%h grant=%b exp=%b busy=%b", i, disp_data, exp_disp(), grant, exp_grant(), busy);
            end
            compared++;
        end
    endtask

    initial begin
        test_reset();
        test_msg();
        test_preempt();
        test_same_cycle();
        test_rerequest();
        test_dismiss();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
